programmer_master: RTL and testbench
====================================

// Module: programmer_master
// PURPOSE
// - Host-side SPI mode-00 transmitter that loads a NUM_BITS configuration word into the on-chip programmer.
// - Drives CS/SCLK/SDI from a single system clock.
// - Generates the CS rising edge that commits the shifted word into the programmer's output register.
// - Sits in the test/FPGA harness between the configuration register file and the chip's SPI pins.
// PARAMETERS
// - NUM_BITS  98  configuration word length; must be >= 2.
// - CLK_DIV   4   clk cycles per SCLK half-period and per CS setup/hold phase; must be >= 1.
// - DRST_LEN  8   clk cycles of the DRESET pulse (used only with PROG_MASTER_DRESET_EN).
// PORTS
// - clk         in   1         system clock; all logic on posedge clk.
// - reset       in   1         synchronous, active-low reset.
// - start       in   1         request a transfer; sampled only in IDLE.
// - data_in     in   NUM_BITS  word to program; captured in the cycle start is accepted.
// - busy        out  1         transfer or DRESET pulse in progress.
// - done        out  1         1-cycle pulse when a transfer has fully committed.
// - CS          out  1         chip select, idle high.
// - SCLK        out  1         serial clock, idle low.
// - SDI         out  1         serial data to the programmer.
// - dreset_req  in   1         digital-reset pulse request; present only with PROG_MASTER_DRESET_EN.
// BEHAVIOUR
// - All outputs are registered.
// - Reset values: CS=1, SCLK=0, SDI=0, busy=0, done=0; state=IDLE; shift register and counters cleared.
// - The programmer decodes CS&SCLK as DRESET and CS&SDI as HO, so in IDLE and LATCH SCLK=0 and SDI=0 always.
// - Bit order: LSB first. data_in[0] is sent first and lands in prog_data[0] after NUM_BITS shifts.
// - Phase counter cnt counts 0..CLK_DIV-1; the phase ends at cnt==CLK_DIV-1.
// - States and outputs:
//   - IDLE: CS=1, SCLK=0, SDI=0. start=1 -> capture data_in into shreg, bitcnt=0 -> LEAD.
//   - LEAD: CS=0, SCLK=0, SDI=shreg[0]; CLK_DIV cycles -> HIGH.
//   - HIGH: SCLK=1, SDI held. The programmer samples on this rising edge. After CLK_DIV cycles:
//     - bitcnt==NUM_BITS-1 -> TAIL;
//     - else shreg>>=1, bitcnt++ -> LOW.
//   - LOW: SCLK=0, SDI=new shreg[0]; CLK_DIV cycles -> HIGH.
//   - TAIL: CS=0, SCLK=0; CLK_DIV cycles -> LATCH.
//   - LATCH: CS=1 (commit edge), SCLK=0, SDI=0; CLK_DIV cycles -> IDLE with done=1 for that one IDLE cycle.
// - Exactly NUM_BITS SCLK rising edges occur per transfer, all with CS=0. SDI changes only while SCLK=0.
// - Timing, with start accepted in cycle 0:
//   - busy=1 in cycles 1..T, where T = CLK_DIV*(2*NUM_BITS+2).
//   - done=1 only in cycle T+1.
// - start asserted together with done is accepted (back-to-back). start while busy is ignored, not queued.
// - data_in changes after capture have no effect on the transfer in progress.
// - Reset mid-transfer: outputs return to idle values on the next clk edge.
//   - The resulting CS rise commits a partial word in the programmer. This is accepted behaviour; the host must reprogram.
// - bitcnt width is $clog2(NUM_BITS); cnt width is $clog2(CLK_DIV)+1. No wrap occurs within a transfer.
// CONFIGURATION
// - PROG_MASTER_DRESET_EN defined:
//   - dreset_req port exists.
//   - In IDLE with start=0 and dreset_req=1 -> DRST state: CS=1, SCLK=1, SDI=0, busy=1 for DRST_LEN cycles, then IDLE. No done pulse.
//   - start has priority when asserted together with dreset_req.
// - PROG_MASTER_DRESET_EN undefined: no dreset_req port and no DRST state. SCLK is never high while CS=1.
// TESTING
// - NUM_BITS=98, CLK_DIV=4, start with data_in=98'h2_AAAA_5555_0F0F_F0F0_1234_5678 -> bench receiver model captures the same word; 98 SCLK rises; done in cycle 793.
// - Back-to-back: start held high through done with a second word -> second transfer starts in cycle 794; receiver holds word 2.
// - start pulsed at cycle 100 mid-transfer, data_in changed -> ignored; first word delivered unchanged.
// - reset low at cycle 300 -> next edge CS=1, SCLK=0, SDI=0, busy=0; no done; a following start completes normally.
// - Protocol checker across all tests: never (CS&SCLK) or (CS&SDI) without the macro; SDI stable at every SCLK rise.
// - With PROG_MASTER_DRESET_EN, DRST_LEN=8: dreset_req in IDLE -> CS&SCLK high for exactly 8 cycles, busy high for those 8; start+dreset_req together -> transfer runs, no DRST pulse.

Source files
------------

// File: rtl/programmer_master.sv
// programmer_master: SPI mode-00 host transmitter that shifts a NUM_BITS word
// LSB first into the on-chip programmer and commits it with a CS rising edge.
// Optional DRESET pulse generator is enabled by defining PROG_MASTER_DRESET_EN.
module programmer_master #(
    parameter int NUM_BITS = 98,
    parameter int CLK_DIV  = 4,
    parameter int DRST_LEN = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_BITS-1:0] data_in,
`ifdef PROG_MASTER_DRESET_EN
    input  logic                dreset_req,
`endif
    output logic                busy,
    output logic                done,
    output logic                CS,
    output logic                SCLK,
    output logic                SDI
);

    localparam int BW = $clog2(NUM_BITS);
    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] CNT_END = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_END = BW'(NUM_BITS - 1);

`ifdef PROG_MASTER_DRESET_EN
    localparam int DW = $clog2(DRST_LEN) + 1;
    localparam logic [DW-1:0] DRST_END = DW'(DRST_LEN - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TAIL,
        LATCH
`ifdef PROG_MASTER_DRESET_EN
        , DRST
`endif
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bitcnt;
    logic [NUM_BITS-1:0]   shreg;
    logic                  phase_end;

`ifdef PROG_MASTER_DRESET_EN
    logic [DW-1:0]         dcnt;
`endif

    assign phase_end = (cnt == CNT_END);

    // Transfer sequencer: every output is set on the edge entering its state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            CS     <= 1'b1;
            SCLK   <= 1'b0;
            SDI    <= 1'b0;
`ifdef PROG_MASTER_DRESET_EN
            dcnt   <= '0;
`endif
        end else begin
            done <= 1'b0;
            cnt  <= phase_end ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        shreg  <= data_in;
                        bitcnt <= '0;
                        SDI    <= data_in[0];
                        CS     <= 1'b0;
                        busy   <= 1'b1;
                        state  <= LEAD;
                    end
`ifdef PROG_MASTER_DRESET_EN
                    else if (dreset_req) begin
                        SCLK  <= 1'b1;
                        busy  <= 1'b1;
                        dcnt  <= '0;
                        state <= DRST;
                    end
`endif
                end
                LEAD: begin
                    if (phase_end) begin
                        SCLK  <= 1'b1;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        SCLK <= 1'b0;
                        if (bitcnt == BIT_END) begin
                            SDI   <= 1'b0;
                            state <= TAIL;
                        end else begin
                            shreg  <= shreg >> 1;
                            bitcnt <= bitcnt + 1'b1;
                            SDI    <= shreg[1];
                            state  <= LOW;
                        end
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        SCLK  <= 1'b1;
                        state <= HIGH;
                    end
                end
                TAIL: begin
                    if (phase_end) begin
                        CS    <= 1'b1;
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
`ifdef PROG_MASTER_DRESET_EN
                DRST: begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == DRST_END) begin
                        SCLK  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_programmer_master.sv
// tb_programmer_master: directed bench with an SPI receiver model and
// a protocol monitor on CS/SCLK/SDI.
`timescale 1ns/1ps
module tb_programmer_master;

    localparam int NB = 98;
    localparam int CD = 4;
    localparam int DL = 8;
    localparam int T  = CD * (2 * NB + 2);

    localparam logic [NB-1:0] W1 = 98'h2_AAAA_5555_0F0F_F0F0_1234_5678;
    localparam logic [NB-1:0] W2 = 98'h1_3579_BDF0_2468_ACE1_DEAD_BEEF;
    localparam logic [NB-1:0] W3 = 98'h3_FFFF_0000_C3C3_3C3C_8001_7FFE;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [NB-1:0] data_in = '0;
    logic          busy, done, CS, SCLK, SDI;
`ifdef PROG_MASTER_DRESET_EN
    logic          dreset_req = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    programmer_master #(.NUM_BITS(NB), .CLK_DIV(CD), .DRST_LEN(DL)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .data_in    (data_in),
`ifdef PROG_MASTER_DRESET_EN
        .dreset_req (dreset_req),
`endif
        .busy       (busy),
        .done       (done),
        .CS         (CS),
        .SCLK       (SCLK),
        .SDI        (SDI)
    );

    // receiver model of the on-chip programmer
    logic [NB-1:0] rx = '0;
    logic [NB-1:0] committed = '0;
    int rises = 0;

    always @(posedge SCLK) begin
        if (CS === 1'b0) begin
            rx = {SDI, rx[NB-1:1]};
            rises++;
        end
    end

    always @(posedge CS) committed = rx;

    // protocol monitor, sampled 2ns after each clock edge
    int   proto_err = 0;
    logic p_sclk = 1'b0;
    logic p_sdi = 1'b0;
    bit   drst_ok = 1'b0;

    always @(posedge clk) begin
        #2;
        if (reset === 1'b1) begin
            if (CS === 1'b1 && SDI !== 1'b0) proto_err++;
            if (CS === 1'b1 && SCLK !== 1'b0 && !drst_ok) proto_err++;
            if (p_sclk == 1'b0 && SCLK === 1'b1 && SDI !== p_sdi) proto_err++;
            if (p_sclk == 1'b1 && SCLK === 1'b1 && SDI !== p_sdi) proto_err++;
        end
        p_sclk = SCLK;
        p_sdi  = SDI;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic do_xfer(input logic [NB-1:0] w, input logic [NB-1:0] w2,
                           input int pert, input int ncyc,
                           output int b_first, output int b_last,
                           output int d_first, output int d_n);
        b_first = -1;
        b_last  = -1;
        d_first = -1;
        d_n     = 0;
        @(negedge clk);
        data_in = w;
        start   = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                if (b_first < 0) b_first = n;
                b_last = n;
            end
            if (done === 1'b1) begin
                if (d_first < 0) d_first = n;
                d_n++;
            end
            if (n == 1) begin
                data_in = w2;
                start   = 1'b0;
            end
            if (n == pert) start = 1'b1;
            if (n == pert + 1) start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (CS !== 1'b1) begin fails++; $display("FAIL reset_cs: got %b want 1", CS); end
        tests++;
        if (SCLK !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b want 0", SCLK); end
        tests++;
        if (SDI !== 1'b0) begin fails++; $display("FAIL reset_sdi: got %b want 0", SDI); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int bf, bl, df, dn, r0;
        r0 = rises;
        do_xfer(W1, W1, -1, T + 5, bf, bl, df, dn);
        tests++;
        if (bf != 1) begin fails++; $display("FAIL basic_busy_first: got %0d want 1", bf); end
        tests++;
        if (bl != T) begin fails++; $display("FAIL basic_busy_last: got %0d want %0d", bl, T); end
        tests++;
        if (df != T + 1) begin fails++; $display("FAIL basic_done_at: got %0d want %0d", df, T + 1); end
        tests++;
        if (dn != 1) begin fails++; $display("FAIL basic_done_count: got %0d want 1", dn); end
        tests++;
        if (rises - r0 != NB) begin fails++; $display("FAIL basic_rises: got %0d want %0d", rises - r0, NB); end
        tests++;
        if (committed !== W1) begin fails++; $display("FAIL basic_word: got %h want %h", committed, W1); end
    endtask

    task automatic test_ignore_start();
        int bf, bl, df, dn, r0;
        r0 = rises;
        do_xfer(W2, W3, 100, T + 5, bf, bl, df, dn);
        tests++;
        if (bl != T) begin fails++; $display("FAIL ignore_busy_last: got %0d want %0d", bl, T); end
        tests++;
        if (df != T + 1) begin fails++; $display("FAIL ignore_done_at: got %0d want %0d", df, T + 1); end
        tests++;
        if (dn != 1) begin fails++; $display("FAIL ignore_done_count: got %0d want 1", dn); end
        tests++;
        if (rises - r0 != NB) begin fails++; $display("FAIL ignore_rises: got %0d want %0d", rises - r0, NB); end
        tests++;
        if (committed !== W2) begin fails++; $display("FAIL ignore_word: got %h want %h", committed, W2); end
    endtask

    task automatic test_back_to_back();
        int d1, d2, dn, bl, r0;
        logic b_t1, b_t2;
        d1 = -1; d2 = -1; dn = 0; bl = -1; r0 = rises;
        b_t1 = 1'bx; b_t2 = 1'bx;
        @(negedge clk);
        data_in = W1;
        start   = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 2 * T + 8; n++) begin
            @(negedge clk);
            if (busy === 1'b1) bl = n;
            if (done === 1'b1) begin
                if (d1 < 0) d1 = n;
                else if (d2 < 0) d2 = n;
                dn++;
            end
            if (n == T + 1) b_t1 = busy;
            if (n == T + 2) begin b_t2 = busy; start = 1'b0; end
            if (n == 1) data_in = W3;
        end
        start = 1'b0;
        tests++;
        if (d1 != T + 1) begin fails++; $display("FAIL b2b_done1_at: got %0d want %0d", d1, T + 1); end
        tests++;
        if (b_t1 !== 1'b0) begin fails++; $display("FAIL b2b_busy_gap: got %b want 0", b_t1); end
        tests++;
        if (b_t2 !== 1'b1) begin fails++; $display("FAIL b2b_busy_restart: got %b want 1", b_t2); end
        tests++;
        if (bl != 2 * T + 1) begin fails++; $display("FAIL b2b_busy_last: got %0d want %0d", bl, 2 * T + 1); end
        tests++;
        if (d2 != 2 * T + 2) begin fails++; $display("FAIL b2b_done2_at: got %0d want %0d", d2, 2 * T + 2); end
        tests++;
        if (dn != 2) begin fails++; $display("FAIL b2b_done_count: got %0d want 2", dn); end
        tests++;
        if (rises - r0 != 2 * NB) begin fails++; $display("FAIL b2b_rises: got %0d want %0d", rises - r0, 2 * NB); end
        tests++;
        if (committed !== W3) begin fails++; $display("FAIL b2b_word: got %h want %h", committed, W3); end
    endtask

    task automatic test_reset_mid();
        int dn, bf, bl, df, dn2;
        logic [4:0] snap;
        dn = 0;
        snap = 'x;
        @(negedge clk);
        data_in = W2;
        start   = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= T + 5; n++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
            if (n == 1) start = 1'b0;
            if (n == 300) reset = 1'b0;
            if (n == 301) begin
                snap  = {CS, SCLK, SDI, busy, done};
                reset = 1'b1;
            end
        end
        tests++;
        if (snap[4] !== 1'b1) begin fails++; $display("FAIL rstmid_cs: got %b want 1", snap[4]); end
        tests++;
        if (snap[3] !== 1'b0) begin fails++; $display("FAIL rstmid_sclk: got %b want 0", snap[3]); end
        tests++;
        if (snap[2] !== 1'b0) begin fails++; $display("FAIL rstmid_sdi: got %b want 0", snap[2]); end
        tests++;
        if (snap[1] !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", snap[1]); end
        tests++;
        if (dn != 0) begin fails++; $display("FAIL rstmid_no_done: got %0d want 0", dn); end
        do_xfer(W1, W2, -1, T + 5, bf, bl, df, dn2);
        tests++;
        if (df != T + 1) begin fails++; $display("FAIL rstmid_after_done_at: got %0d want %0d", df, T + 1); end
        tests++;
        if (committed !== W1) begin fails++; $display("FAIL rstmid_after_word: got %h want %h", committed, W1); end
    endtask

`ifdef PROG_MASTER_DRESET_EN
    task automatic test_dreset();
        int hi, bz, df, r0;
        hi = 0; bz = 0; df = -1; r0 = rises;
        @(negedge clk);
        dreset_req = 1'b1;
        drst_ok    = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) dreset_req = 1'b0;
            if (CS === 1'b1 && SCLK === 1'b1) hi++;
            if (busy === 1'b1) bz++;
        end
        drst_ok = 1'b0;
        tests++;
        if (hi != DL) begin fails++; $display("FAIL drst_pulse_len: got %0d want %0d", hi, DL); end
        tests++;
        if (bz != DL) begin fails++; $display("FAIL drst_busy_len: got %0d want %0d", bz, DL); end
        hi = 0;
        @(negedge clk);
        data_in    = W3;
        start      = 1'b1;
        dreset_req = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= T + 5; n++) begin
            @(negedge clk);
            if (n == 1) begin start = 1'b0; dreset_req = 1'b0; end
            if (CS === 1'b1 && SCLK === 1'b1) hi++;
            if (done === 1'b1 && df < 0) df = n;
        end
        tests++;
        if (hi != 0) begin fails++; $display("FAIL drst_prio_pulse: got %0d want 0", hi); end
        tests++;
        if (df != T + 1) begin fails++; $display("FAIL drst_prio_done_at: got %0d want %0d", df, T + 1); end
        tests++;
        if (committed !== W3) begin fails++; $display("FAIL drst_prio_word: got %h want %h", committed, W3); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
`ifdef PROG_MASTER_DRESET_EN
        test_dreset();
`endif
        repeat (2) @(negedge clk);
        tests++;
        if (proto_err != 0) begin fails++; $display("FAIL protocol: got %0d violations want 0", proto_err); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
